// File: rtl/weight_loader_param.sv
// Streams one output channel of PE weights at a time from a synchronous weight ROM.
// Define WLOAD_PREFETCH_EN to add a shadow buffer that prefetches the next channel.
module weight_loader_param #(
  parameter int W_BITS     = 7,
  parameter int W_PER_WORD = 4,
  parameter int PE_NUM     = 8,
  parameter int CH_NUM     = 16,
  parameter int ADDR_W     = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic [ADDR_W-1:0]            base_addr_i,
  output logic                         rom_en_o,
  output logic [ADDR_W-1:0]            rom_addr_o,
  input  logic [W_PER_WORD*W_BITS-1:0] rom_data_i,
  output logic [PE_NUM*W_BITS-1:0]     w_flat_o,
  output logic                         w_valid_o,
  input  logic                         ch_ready_i,
  output logic [CH_NUM-1:0]            new_weight_val_o,
  output logic                         busy_o,
  output logic                         done_o
);
  localparam int WPC = PE_NUM / W_PER_WORD;
  localparam int DW  = W_PER_WORD * W_BITS;
  localparam int FW  = PE_NUM * W_BITS;
  localparam int KW  = (WPC > 1) ? $clog2(WPC) : 1;
  localparam int CW  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WPC - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CH_NUM - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [KW-1:0]     k_q, k_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [FW-1:0]     flat_q, flat_d;
  logic [CH_NUM-1:0] nwv_q, nwv_d;
  logic              rd_vld_q;
  logic [KW-1:0]     rd_idx_q;
  logic              rd_issue;
  logic              last_ch;

  // Word k, field j (MSB first) lands on PE k*W_PER_WORD + j.
  function automatic logic [FW-1:0] put_word(input logic [FW-1:0] flat,
                                             input logic [KW-1:0] idx,
                                             input logic [DW-1:0] word);
    logic [FW-1:0] r;
    r = flat;
    for (int j = 0; j < W_PER_WORD; j++)
      r[(int'(idx) * W_PER_WORD + j) * W_BITS +: W_BITS] = word[DW - 1 - j * W_BITS -: W_BITS];
    return r;
  endfunction

`ifdef WLOAD_PREFETCH_EN
  logic          pf_act_q, pf_act_d;
  logic          rd_pf_q;
  logic [FW-1:0] shadow_q, shadow_d;
  logic          sh_full_q, sh_full_d;
  logic          sh_last;

  assign rd_issue = (state_q == S_FETCH) || pf_act_q;
  assign sh_last  = rd_vld_q && rd_pf_q && (rd_idx_q == K_LAST);
`else
  assign rd_issue = (state_q == S_FETCH);
`endif

  assign last_ch = (ch_q == C_LAST);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    k_d     = k_q;
    ch_d    = ch_q;
    flat_d  = flat_q;
    nwv_d   = nwv_q;
`ifdef WLOAD_PREFETCH_EN
    pf_act_d  = pf_act_q;
    shadow_d  = shadow_q;
    sh_full_d = sh_full_q;
    if (rd_vld_q && rd_pf_q)
      shadow_d = put_word(shadow_q, rd_idx_q, rom_data_i);
    if (sh_last)
      sh_full_d = 1'b1;
    if (pf_act_q && (k_q == K_LAST))
      pf_act_d = 1'b0;
    if (rd_vld_q && !rd_pf_q)
      flat_d = put_word(flat_q, rd_idx_q, rom_data_i);
`else
    if (rd_vld_q)
      flat_d = put_word(flat_q, rd_idx_q, rom_data_i);
`endif
    if (rd_issue) begin
      addr_d = addr_q + ADDR_W'(1);
      k_d    = (k_q == K_LAST) ? '0 : k_q + KW'(1);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_FETCH;
          addr_d  = base_addr_i;
          k_d     = '0;
          ch_d    = '0;
          nwv_d   = '0;
        end
      end
      S_FETCH: begin
        if (k_q == K_LAST)
          state_d = S_FILL;
      end
      S_FILL: begin
`ifdef WLOAD_PREFETCH_EN
        // Channel 0 is fetched directly; later channels wait for the shadow.
        if ((ch_q == '0) || sh_full_q || sh_last) begin
          if (ch_q != '0) begin
            flat_d    = shadow_d;
            sh_full_d = 1'b0;
          end
          state_d     = S_HOLD;
          nwv_d[ch_q] = 1'b1;
          pf_act_d    = !last_ch;
        end
`else
        state_d     = S_HOLD;
        nwv_d[ch_q] = 1'b1;
`endif
      end
      S_HOLD: begin
        if (ch_ready_i) begin
          if (last_ch) begin
            state_d = S_DONE;
          end else begin
            ch_d = ch_q + CW'(1);
`ifdef WLOAD_PREFETCH_EN
            state_d = S_FILL;
`else
            state_d = S_FETCH;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      k_q      <= '0;
      ch_q     <= '0;
      flat_q   <= '0;
      nwv_q    <= '0;
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      k_q      <= k_d;
      ch_q     <= ch_d;
      flat_q   <= flat_d;
      nwv_q    <= nwv_d;
      rd_vld_q <= rd_issue;
      rd_idx_q <= k_q;
    end
  end

`ifdef WLOAD_PREFETCH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf_act_q  <= 1'b0;
      rd_pf_q   <= 1'b0;
      sh_full_q <= 1'b0;
    end else begin
      pf_act_q  <= pf_act_d;
      rd_pf_q   <= pf_act_q;
      sh_full_q <= sh_full_d;
    end
  end

  // Shadow contents are only consumed once every slice has been rewritten.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end
`endif

  assign rom_en_o         = rd_issue;
  assign rom_addr_o       = addr_q;
  assign w_flat_o         = flat_q;
  assign w_valid_o        = (state_q == S_HOLD);
  assign new_weight_val_o = nwv_q;
  assign busy_o           = (state_q == S_FETCH) || (state_q == S_FILL) || (state_q == S_HOLD);
  assign done_o           = (state_q == S_DONE);

endmodule

// File: tb/tb_weight_loader_param.sv
// Directed bench for weight_loader_param: default instance plus a W_PER_WORD=2,
// CH_NUM=4 instance. Timing expectations follow WLOAD_PREFETCH_EN when defined.
`timescale 1ns/1ps
module tb_weight_loader_param;
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  base  = '0;
  logic        en;
  logic [4:0]  addr;
  logic [27:0] rdata = '0;
  logic [55:0] wf;
  logic        wv;
  logic        rdy   = 1'b1;
  logic [15:0] nwv;
  logic        busy, done;

  logic        start2 = 1'b0;
  logic [4:0]  base2  = '0;
  logic        en2;
  logic [4:0]  addr2;
  logic [13:0] rdata2 = '0;
  logic [55:0] wf2;
  logic        wv2;
  logic        rdy2   = 1'b0;
  logic [3:0]  nwv2;
  logic        busy2, done2;

  int cyc   = 0;
  int n_chk = 0;
  int n_err = 0;
  int acc   = 0;
  int a0    = 0;
  int cs    = 0;

  always #5 clk = ~clk;

  weight_loader_param dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .base_addr_i(base),
    .rom_en_o(en), .rom_addr_o(addr), .rom_data_i(rdata),
    .w_flat_o(wf), .w_valid_o(wv), .ch_ready_i(rdy),
    .new_weight_val_o(nwv), .busy_o(busy), .done_o(done)
  );

  weight_loader_param #(.W_PER_WORD(2), .CH_NUM(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start2), .base_addr_i(base2),
    .rom_en_o(en2), .rom_addr_o(addr2), .rom_data_i(rdata2),
    .w_flat_o(wf2), .w_valid_o(wv2), .ch_ready_i(rdy2),
    .new_weight_val_o(nwv2), .busy_o(busy2), .done_o(done2)
  );

  // Word n = {n, n+1, n+2, n+3}; second ROM word n = {2n+1, 2n+2}.
  always_ff @(posedge clk) begin
    if (en)  rdata  <= {7'(int'(addr)), 7'(int'(addr) + 1), 7'(int'(addr) + 2), 7'(int'(addr) + 3)};
    if (en2) rdata2 <= {7'(2 * int'(addr2) + 1), 7'(2 * int'(addr2) + 2)};
  end

  always @(posedge clk) if (wv && rdy) acc <= acc + 1;

  function automatic logic [55:0] flat8(input int p0, input int p1, input int p2, input int p3,
                                        input int p4, input int p5, input int p6, input int p7);
    return {7'(p7), 7'(p6), 7'(p5), 7'(p4), 7'(p3), 7'(p2), 7'(p1), 7'(p0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  typedef struct packed {
    int          cyc;
    logic        en;
    logic [4:0]  addr;
    logic        wv;
    logic        busy;
    logic        done;
    logic [15:0] nwv;
    logic        cw;
    logic [55:0] w;
  } vec_t;

  vec_t vt[8];

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef WLOAD_PREFETCH_EN
    vt[0] = '{1,  1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 56'd0};
    vt[1] = '{2,  1'b1, 5'd1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 56'd0};
    vt[2] = '{3,  1'b0, 5'd2, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 56'd0};
    vt[3] = '{4,  1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b1, flat8(0, 1, 2, 3, 1, 2, 3, 4)};
    vt[4] = '{5,  1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b1, flat8(0, 1, 2, 3, 1, 2, 3, 4)};
    vt[5] = '{7,  1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 16'h0003, 1'b1, flat8(2, 3, 4, 5, 3, 4, 5, 6)};
    vt[6] = '{49, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b1, flat8(30, 31, 32, 33, 31, 32, 33, 34)};
    vt[7] = '{50, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1, flat8(30, 31, 32, 33, 31, 32, 33, 34)};
`else
    vt[0] = '{1,  1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 56'd0};
    vt[1] = '{2,  1'b1, 5'd1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 56'd0};
    vt[2] = '{3,  1'b0, 5'd2, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 56'd0};
    vt[3] = '{4,  1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b1, flat8(0, 1, 2, 3, 1, 2, 3, 4)};
    vt[4] = '{5,  1'b1, 5'd2, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b1, flat8(0, 1, 2, 3, 1, 2, 3, 4)};
    vt[5] = '{8,  1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 16'h0003, 1'b1, flat8(2, 3, 4, 5, 3, 4, 5, 6)};
    vt[6] = '{64, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b1, flat8(30, 31, 32, 33, 31, 32, 33, 34)};
    vt[7] = '{65, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1, flat8(30, 31, 32, 33, 31, 32, 33, 34)};
`endif

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_rom_en", en, 1'b0);
    chk("rst_rom_addr", addr, 5'd0);
    chk("rst_w_flat", wf, 56'd0);
    chk("rst_w_valid", wv, 1'b0);
    chk("rst_nwv", nwv, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    step();

    // Run 1: base 0, ch_ready high, checkpoints from the table.
    start = 1'b1;
    base  = 5'd0;
    cyc   = 0;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      while (cyc < vt[i].cyc) step();
      chk($sformatf("v%0d_rom_en", i), en, vt[i].en);
      chk($sformatf("v%0d_rom_addr", i), addr, vt[i].addr);
      chk($sformatf("v%0d_w_valid", i), wv, vt[i].wv);
      chk($sformatf("v%0d_busy", i), busy, vt[i].busy);
      chk($sformatf("v%0d_done", i), done, vt[i].done);
      chk($sformatf("v%0d_nwv", i), nwv, vt[i].nwv);
      if (vt[i].cw) chk($sformatf("v%0d_w_flat", i), wf, vt[i].w);
    end

    // Restart from DONE with base 2; stall on channel 3, stray start on channel 5.
    start = 1'b1;
    base  = 5'd2;
    cs    = cyc;
    step();
    start = 1'b0;
    a0    = acc;
    chk("rs_done_clr", done, 1'b0);
    chk("rs_nwv_clr", nwv, 16'h0);
    chk("rs_busy", busy, 1'b1);
    chk("rs_rom_addr", addr, 5'd2);
    for (int k = 0; k < 20 && !wv; k++) step();
    chk("rs_wv_timeout", wv, 1'b1);
    chk("rs_wv_cycle", 64'(cyc - cs), 64'd4);
    chk("rs_ch0_w_flat", wf, flat8(2, 3, 4, 5, 3, 4, 5, 6));

    for (int k = 0; k < 100 && !(nwv == 16'h0007 && !wv); k++) step();
    chk("st_ch3_wait", nwv, 16'h0007);
    rdy = 1'b0;
    for (int k = 0; k < 20 && !wv; k++) step();
    chk("st_wv_timeout", wv, 1'b1);
    chk("st_nwv", nwv, 16'h000F);
    chk("st_w_flat", wf, flat8(8, 9, 10, 11, 9, 10, 11, 12));
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("stall_w_valid", wv, 1'b1);
      chk("stall_w_flat", wf, flat8(8, 9, 10, 11, 9, 10, 11, 12));
      chk("stall_nwv", nwv, 16'h000F);
`ifdef WLOAD_PREFETCH_EN
      if (i >= 2) chk("stall_rom_en", en, 1'b0);
`else
      chk("stall_rom_en", en, 1'b0);
`endif
    end
    rdy = 1'b1;
    step();
    chk("st_release_wv", wv, 1'b0);

    for (int k = 0; k < 100 && !(nwv == 16'h003F && wv); k++) step();
    chk("bz_ch5_wait", nwv, 16'h003F);
    start = 1'b1;
    base  = 5'd7;
    step();
    start = 1'b0;
    chk("bz_nwv_kept", nwv, 16'h003F);
    chk("bz_busy", busy, 1'b1);
    for (int k = 0; k < 200 && !done; k++) step();
    chk("bz_done_timeout", done, 1'b1);
    chk("bz_accepts", 64'(acc - a0), 64'd16);
    chk("bz_ch15_w_flat", wf, flat8(0, 1, 2, 3, 1, 2, 3, 4));
    step();
    step();
    chk("bz_done_sticky", done, 1'b1);

    // Base 20: channel 6 wraps to ROM words 0 and 1.
    start = 1'b1;
    base  = 5'd20;
    step();
    start = 1'b0;
    a0    = acc;
    for (int k = 0; k < 100 && !(nwv == 16'h007F && wv); k++) step();
    chk("wr_ch6_wait", nwv, 16'h007F);
    chk("wr_ch6_w_flat", wf, flat8(0, 1, 2, 3, 1, 2, 3, 4));
    for (int k = 0; k < 200 && !done; k++) step();
    chk("wr_done_timeout", done, 1'b1);
    chk("wr_accepts", 64'(acc - a0), 64'd16);
    chk("wr_busy", busy, 1'b0);

    // Reset mid channel 9.
    start = 1'b1;
    base  = 5'd0;
    step();
    start = 1'b0;
    for (int k = 0; k < 100 && !(nwv == 16'h01FF && !wv); k++) step();
    chk("rm_ch9_wait", nwv, 16'h01FF);
    rst_n = 1'b0;
    #1;
    chk("rm_rom_en", en, 1'b0);
    chk("rm_rom_addr", addr, 5'd0);
    chk("rm_w_flat", wf, 56'd0);
    chk("rm_w_valid", wv, 1'b0);
    chk("rm_nwv", nwv, 16'h0);
    chk("rm_busy", busy, 1'b0);
    chk("rm_done", done, 1'b0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rm_idle_rom_en", en, 1'b0);
      chk("rm_idle_busy", busy, 1'b0);
    end

    // Second instance: WPC=4, unpacking of all eight PEs.
    start2 = 1'b1;
    cs     = cyc;
    step();
    start2 = 1'b0;
    chk("p2_busy", busy2, 1'b1);
    for (int k = 0; k < 20 && !wv2; k++) step();
    chk("p2_wv_timeout", wv2, 1'b1);
    chk("p2_wv_cycle", 64'(cyc - cs), 64'd6);
    chk("p2_nwv", nwv2, 4'b0001);
    chk("p2_ch0_w_flat", wf2, flat8(1, 2, 3, 4, 5, 6, 7, 8));
    rdy2 = 1'b1;
    step();
    chk("p2_accept_wv", wv2, 1'b0);
    for (int k = 0; k < 20 && !wv2; k++) step();
    chk("p2_ch1_wv_timeout", wv2, 1'b1);
    chk("p2_ch1_w_flat", wf2, flat8(9, 10, 11, 12, 13, 14, 15, 16));
    for (int k = 0; k < 50 && !done2; k++) step();
    chk("p2_done", done2, 1'b1);
    chk("p2_rom_en_idle", en2, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
